// File: rtl/grf_sb.sv
// General register file for the pipelined MIPS datapath: N combinational read ports with
// write-through bypass, a per-register pending-write scoreboard, and a registered commit trace.
module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [31:0]             wpc,
    input  logic [NRD*ADDR_W-1:0]   ra,
    output logic [NRD*DATA_W-1:0]   rd,
    output logic [NRD-1:0]          rbusy,
    input  logic                    iss,
    input  logic [ADDR_W-1:0]       ia,
    output logic                    trc_v,
    output logic [31:0]             trc_pc,
    output logic [ADDR_W-1:0]       trc_a,
    output logic [DATA_W-1:0]       trc_d
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_trc_v;
    logic [31:0]       r_trc_pc;
    logic [ADDR_W-1:0] r_trc_a;
    logic [DATA_W-1:0] r_trc_d;

    logic              w_wr_en;
    logic              w_iss_en;
    logic [DEPTH-1:0]  w_busy_next;

    assign w_wr_en  = we && (wa != '0);
    assign w_iss_en = iss && (ia != '0);

    // Issue is applied after the write clear: a same-edge issue is the younger producer.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[wa] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[ia] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy   <= '0;
            r_trc_v  <= 1'b0;
            r_trc_pc <= '0;
            r_trc_a  <= '0;
            r_trc_d  <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[wa] <= wd;
                r_trc_pc   <= wpc;
                r_trc_a    <= wa;
                r_trc_d    <= wd;
            end
            r_trc_v <= w_wr_en;
            r_busy  <= w_busy_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;

        assign w_ra  = ra[k*ADDR_W +: ADDR_W];
        // The write landing this cycle is forwarded, so it also hides that register's busy bit.
        assign w_hit = w_wr_en && (wa == w_ra);
        assign rd[k*DATA_W +: DATA_W] = (w_ra == '0) ? '0 :
                                        w_hit        ? wd : r_regs[w_ra];
        assign rbusy[k] = (w_ra != '0) && r_busy[w_ra] && !w_hit;
    end

    assign trc_v  = r_trc_v;
    assign trc_pc = r_trc_pc;
    assign trc_a  = r_trc_a;
    assign trc_d  = r_trc_d;

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: two instances (NRD=2 and NRD=3) driven in lockstep, expected
// read/trace responses queued by the stimulus and checked by a negedge monitor.
module tb_grf_sb;

    typedef struct packed {
        logic        kind;   // 0: read port check, 1: idle trace register check
        logic        dut;
        logic [1:0]  port;
        logic        busy;
        logic [31:0] d;
        logic [31:0] pc;
        logic [4:0]  a;
    } probe_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra [3];

    logic [9:0]  ra0;
    logic [14:0] ra1;
    logic [63:0] rd0;
    logic [95:0] rd1;
    logic [1:0]  rbusy0;
    logic [2:0]  rbusy1;
    logic        trc_v0, trc_v1;
    logic [31:0] trc_pc0, trc_pc1;
    logic [4:0]  trc_a0, trc_a1;
    logic [31:0] trc_d0, trc_d1;

    probe_t      exp_q[$];
    logic [68:0] trc_q0[$];
    logic [68:0] trc_q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    assign ra0 = {ra[1], ra[0]};
    assign ra1 = {ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    grf_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) u_dut0 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .ra(ra0), .rd(rd0), .rbusy(rbusy0), .iss(iss), .ia(ia),
        .trc_v(trc_v0), .trc_pc(trc_pc0), .trc_a(trc_a0), .trc_d(trc_d0)
    );

    grf_sb #(.DATA_W(32), .ADDR_W(5), .NRD(3)) u_dut1 (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .ra(ra1), .rd(rd1), .rbusy(rbusy1), .iss(iss), .ia(ia),
        .trc_v(trc_v1), .trc_pc(trc_pc1), .trc_a(trc_a1), .trc_d(trc_d1)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic chk_trace(input int dut, input logic v, input logic [31:0] pc,
                             input logic [4:0] a, input logic [31:0] d);
        logic [68:0] e;
        n_chk++;
        if (dut == 0 ? trc_q0.size() == 0 : trc_q1.size() == 0) begin
            $display("FAIL trace dut%0d: unexpected trc_v=%0b pc=0x%0h a=%0d d=0x%0h (t=%0t)",
                     dut, v, pc, a, d, $time);
        end else begin
            e = (dut == 0) ? trc_q0.pop_front() : trc_q1.pop_front();
            if ({pc, a, d} === e) n_pass++;
            else $display("FAIL trace dut%0d: got pc=0x%0h a=%0d d=0x%0h, expected pc=0x%0h a=%0d d=0x%0h",
                          dut, pc, a, d, e[68:37], e[36:32], e[31:0]);
        end
    endtask

    // Monitor: drains queued read/idle probes and consumes trace beats whenever trc_v is high.
    always @(negedge clk) begin
        probe_t      it;
        int          p;
        logic [31:0] got_d;
        logic        got_b;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            p  = int'(it.port);
            if (it.kind == 1'b0) begin
                got_d = it.dut ? rd1[p*32 +: 32] : rd0[p*32 +: 32];
                got_b = it.dut ? rbusy1[p] : rbusy0[p];
                chk($sformatf("rd dut%0d p%0d", it.dut, p), 128'(got_d), 128'(it.d));
                chk($sformatf("rbusy dut%0d p%0d", it.dut, p), 128'(got_b), 128'(it.busy));
            end else if (it.dut == 1'b0) begin
                chk("trc idle dut0", 128'({trc_v0, trc_pc0, trc_a0, trc_d0}),
                    128'({1'b0, it.pc, it.a, it.d}));
            end else begin
                chk("trc idle dut1", 128'({trc_v1, trc_pc1, trc_a1, trc_d1}),
                    128'({1'b0, it.pc, it.a, it.d}));
            end
        end
        if (trc_v0 === 1'b1) chk_trace(0, trc_v0, trc_pc0, trc_a0, trc_d0);
        if (trc_v1 === 1'b1) chk_trace(1, trc_v1, trc_pc1, trc_a1, trc_d1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        iss   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        we  = 1'b1;
        wa  = a;
        wd  = d;
        wpc = pc;
        if (a != 5'd0 && !reset) begin
            trc_q0.push_back({pc, a, d});
            trc_q1.push_back({pc, a, d});
        end
    endtask

    task automatic issue(input logic [4:0] a);
        iss = 1'b1;
        ia  = a;
    endtask

    // Sets port address and queues the expected read; port 2 exists only on the NRD=3 instance.
    task automatic prb(input int port, input logic [4:0] a, input logic b, input logic [31:0] d);
        probe_t it;
        ra[port] = a;
        it = '{kind: 1'b0, dut: 1'b1, port: 2'(port), busy: b, d: d, pc: '0, a: '0};
        if (port < 2) begin
            it.dut = 1'b0;
            exp_q.push_back(it);
            it.dut = 1'b1;
        end
        exp_q.push_back(it);
    endtask

    task automatic prb_idle(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{kind: 1'b1, dut: 1'b0, port: '0, busy: 1'b0, d: d, pc: pc, a: a});
        exp_q.push_back('{kind: 1'b1, dut: 1'b1, port: '0, busy: 1'b0, d: d, pc: pc, a: a});
    endtask

    initial begin
        reset = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'hDEAD_0004; wpc = 32'h0;
        iss = 1'b1; ia = 5'd4;
        ra[0] = 5'd5; ra[1] = 5'd31; ra[2] = 5'd7;

        // Out of reset: everything zero, the reset-cycle write/issue discarded.
        step();
        prb(0, 5'd5, 1'b0, 32'h0);
        prb(1, 5'd31, 1'b0, 32'h0);
        prb(2, 5'd4, 1'b0, 32'h0);
        prb_idle(32'h0, 5'd0, 32'h0);

        step();
        wr(5'd3, 32'h1234_5678, 32'h0000_3000);
        prb(0, 5'd3, 1'b0, 32'h1234_5678);

        step();
        prb(0, 5'd3, 1'b0, 32'h1234_5678);

        // Register 0: write and issue are ignored.
        step();
        wr(5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
        issue(5'd0);
        prb(0, 5'd0, 1'b0, 32'h0);
        prb(1, 5'd3, 1'b0, 32'h1234_5678);

        step();
        prb(0, 5'd0, 1'b0, 32'h0);
        prb_idle(32'h0000_3000, 5'd3, 32'h1234_5678);
        issue(5'd8);
        prb(1, 5'd8, 1'b0, 32'h0);

        step();
        issue(5'd8);
        prb(1, 5'd8, 1'b1, 32'h0);

        step();
        prb(1, 5'd8, 1'b1, 32'h0);

        step();
        wr(5'd8, 32'hCAFE_F00D, 32'h0000_3010);
        issue(5'd9);
        prb(1, 5'd8, 1'b0, 32'hCAFE_F00D);
        prb(0, 5'd9, 1'b0, 32'h0);

        step();
        prb(1, 5'd8, 1'b0, 32'hCAFE_F00D);
        prb(0, 5'd9, 1'b1, 32'h0);

        // Same-edge write and re-issue of register 9.
        step();
        wr(5'd9, 32'h9999_0000, 32'h0000_3014);
        issue(5'd9);
        prb(0, 5'd9, 1'b0, 32'h9999_0000);

        step();
        prb(0, 5'd9, 1'b1, 32'h9999_0000);
        issue(5'd4);
        prb(1, 5'd4, 1'b0, 32'h0);

        step();
        wr(5'd4, 32'hA5A5_A5A5, 32'h0000_3018);
        issue(5'd4);
        prb(1, 5'd4, 1'b0, 32'hA5A5_A5A5);

        step();
        prb(1, 5'd4, 1'b1, 32'hA5A5_A5A5);
        prb(2, 5'd4, 1'b1, 32'hA5A5_A5A5);

        // Reset mid-flight together with a write to register 4.
        step();
        reset = 1'b1;
        wr(5'd4, 32'h1111_1111, 32'h0000_301C);

        step();
        prb(1, 5'd4, 1'b0, 32'h0);
        prb(2, 5'd4, 1'b0, 32'h0);
        prb(0, 5'd9, 1'b0, 32'h0);
        prb_idle(32'h0, 5'd0, 32'h0);

        step();
        wr(5'd17, 32'h1357_2468, 32'h0000_3020);
        issue(5'd20);
        ra[0] = 5'd5; ra[1] = 5'd6;
        prb(2, 5'd17, 1'b0, 32'h1357_2468);

        step();
        prb(2, 5'd20, 1'b1, 32'h0);
        prb(0, 5'd17, 1'b0, 32'h1357_2468);
        prb(1, 5'd20, 1'b1, 32'h0);

        step();
        prb(2, 5'd17, 1'b0, 32'h1357_2468);

        repeat (3) step();
        chk("trace drained dut0", 128'(trc_q0.size()), 128'(0));
        chk("trace drained dut1", 128'(trc_q1.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
